// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM states, grant owner
// encoding and the default pipeline/interface sizing parameters.
package mem_port_arbiter_pkg;

  localparam int          DEFAULT_XLEN      = 32;
  localparam int          DEFAULT_ADDR_SIZE = 32;
  localparam int unsigned DEFAULT_TIMEOUT   = 255;
  localparam int          WDOG_W            = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_F    = 2'd1,
    GNT_E_RD = 2'd2,
    GNT_E_WR = 2'd3
  } arb_state_e;

  typedef enum logic {
    GRANT_F = 1'b0,
    GRANT_E = 1'b1
  } grant_e;

endpackage

// File: rtl/arb_watchdog.sv
// Grant watchdog: counts read-grant cycles without a memory response and
// flags expiry on the cycle the count reaches TIMEOUT.
module arb_watchdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT - 1);

  logic [WDOG_W-1:0] count;

  // The first grant cycle sees count==0, so expiry lands on the TIMEOUT-th idle cycle.
  assign expired = tick && (count == LAST);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear || expired) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and execute load/store,
// with round-robin on contention and read-modify-write sequencing for stores.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int          XLEN           = DEFAULT_XLEN,
  parameter int          READ_ADDR_SIZE = DEFAULT_ADDR_SIZE,
  parameter int unsigned TIMEOUT        = DEFAULT_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      f_readEn,
  input  logic [READ_ADDR_SIZE-1:0] f_readAddr,
  output logic                      f_readFin,
  output logic [XLEN-1:0]           f_readData,
  input  logic                      e_reqEn,
  input  logic                      e_isStore,
  input  logic [READ_ADDR_SIZE-1:0] e_addr,
  input  logic [XLEN-1:0]           e_writeData,
  output logic                      e_fin,
  output logic [XLEN-1:0]           e_readData,
  output logic                      mem_readEn,
  output logic                      mem_writeEn,
  output logic [READ_ADDR_SIZE-1:0] mem_readAddr,
  output logic [READ_ADDR_SIZE-1:0] mem_writeAddr,
  output logic [XLEN-1:0]           mem_writeData,
  input  logic                      mem_readFin,
  input  logic [XLEN-1:0]           mem_radData,
  output logic                      timeoutErr
);

  arb_state_e      state, state_d;
  grant_e          last_grant, last_grant_d;
  logic [XLEN-1:0] old_word, old_word_d;
  logic            rd_grant, wd_expired;

  assign rd_grant = (state == GNT_F) || (state == GNT_E_RD);

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (!rd_grant),
    .tick    (rd_grant && !mem_readFin),
    .expired (wd_expired)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d       = state;
    last_grant_d  = last_grant;
    old_word_d    = old_word;
    f_readFin     = 1'b0;
    f_readData    = '0;
    e_fin         = 1'b0;
    e_readData    = '0;
    mem_readEn    = 1'b0;
    mem_writeEn   = 1'b0;
    mem_readAddr  = '0;
    mem_writeAddr = '0;
    mem_writeData = '0;
    timeoutErr    = 1'b0;
    // Outputs are decoded from the registered state, so reset must mask them
    // in the same cycle to abort a pending write or completion.
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (e_reqEn && (!f_readEn || last_grant != GRANT_E)) state_d = GNT_E_RD;
          else if (f_readEn)                                 state_d = GNT_F;
        end
        GNT_F: begin
          mem_readEn   = 1'b1;
          mem_readAddr = f_readAddr;
          if (mem_readFin) begin
            f_readFin    = 1'b1;
            f_readData   = mem_radData;
            state_d      = IDLE;
            last_grant_d = GRANT_F;
          end else if (wd_expired) begin
            timeoutErr   = 1'b1;
            state_d      = IDLE;
            last_grant_d = GRANT_F;
          end
        end
        GNT_E_RD: begin
          mem_readEn   = 1'b1;
          mem_readAddr = e_addr;
          if (mem_readFin) begin
            if (e_isStore) begin
              old_word_d = mem_radData;
              state_d    = GNT_E_WR;
            end else begin
              e_fin        = 1'b1;
              e_readData   = mem_radData;
              state_d      = IDLE;
              last_grant_d = GRANT_E;
            end
          end else if (wd_expired) begin
            timeoutErr   = 1'b1;
            state_d      = IDLE;
            last_grant_d = GRANT_E;
          end
        end
        GNT_E_WR: begin
          mem_writeEn   = 1'b1;
          mem_writeAddr = e_addr;
          mem_writeData = e_writeData;
          e_fin         = 1'b1;
          e_readData    = old_word;
          state_d       = IDLE;
          last_grant_d  = GRANT_E;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_F;
      old_word   <= '0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      old_word   <= old_word_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter: one vector per clock,
// inputs applied and outputs compared in the low phase of the clock.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        rst;
    logic        f_en;
    logic [31:0] f_addr;
    logic        e_en;
    logic        e_st;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic        m_fin;
    logic [31:0] m_data;
  } in_t;

  typedef struct packed {
    logic        f_fin;
    logic [31:0] f_data;
    logic        e_fin;
    logic [31:0] e_data;
    logic        rd;
    logic [31:0] raddr;
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        to;
  } out_t;

  typedef struct {
    string name;
    in_t   in;
    out_t  exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_readEn = 1'b0, e_reqEn = 1'b0, e_isStore = 1'b0, mem_readFin = 1'b0;
  logic [31:0] f_readAddr = '0, e_addr = '0, e_writeData = '0, mem_radData = '0;
  logic        f_readFin, e_fin, mem_readEn, mem_writeEn, timeoutErr;
  logic [31:0] f_readData, e_readData, mem_readAddr, mem_writeAddr, mem_writeData;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .f_readEn     (f_readEn),
    .f_readAddr   (f_readAddr),
    .f_readFin    (f_readFin),
    .f_readData   (f_readData),
    .e_reqEn      (e_reqEn),
    .e_isStore    (e_isStore),
    .e_addr       (e_addr),
    .e_writeData  (e_writeData),
    .e_fin        (e_fin),
    .e_readData   (e_readData),
    .mem_readEn   (mem_readEn),
    .mem_writeEn  (mem_writeEn),
    .mem_readAddr (mem_readAddr),
    .mem_writeAddr(mem_writeAddr),
    .mem_writeData(mem_writeData),
    .mem_readFin  (mem_readFin),
    .mem_radData  (mem_radData),
    .timeoutErr   (timeoutErr)
  );

  function automatic in_t mk_in(input logic r, input logic fe, input logic [31:0] fa,
                                input logic ee, input logic es, input logic [31:0] ea,
                                input logic [31:0] ewd, input logic mf, input logic [31:0] md);
    in_t i;
    i = '{rst: r, f_en: fe, f_addr: fa, e_en: ee, e_st: es, e_addr: ea, e_wd: ewd, m_fin: mf, m_data: md};
    return i;
  endfunction

  function automatic out_t o_none();
    return '0;
  endfunction

  function automatic out_t o_rd(input logic [31:0] a);
    out_t o;
    o = '0;
    o.rd = 1'b1;
    o.raddr = a;
    return o;
  endfunction

  function automatic out_t o_ffin(input logic [31:0] a, input logic [31:0] d);
    out_t o;
    o = o_rd(a);
    o.f_fin = 1'b1;
    o.f_data = d;
    return o;
  endfunction

  function automatic out_t o_efin(input logic [31:0] a, input logic [31:0] d);
    out_t o;
    o = o_rd(a);
    o.e_fin = 1'b1;
    o.e_data = d;
    return o;
  endfunction

  function automatic out_t o_wr(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] old);
    out_t o;
    o = '0;
    o.wr = 1'b1;
    o.waddr = a;
    o.wdata = wd;
    o.e_fin = 1'b1;
    o.e_data = old;
    return o;
  endfunction

  task automatic add(input string name, input in_t i, input out_t o);
    vec_t v;
    v.name = name;
    v.in = i;
    v.exp = o;
    tbl.push_back(v);
  endtask

  task automatic check(input vec_t v);
    out_t got;
    @(negedge clk);
    rst         = v.in.rst;
    f_readEn    = v.in.f_en;
    f_readAddr  = v.in.f_addr;
    e_reqEn     = v.in.e_en;
    e_isStore   = v.in.e_st;
    e_addr      = v.in.e_addr;
    e_writeData = v.in.e_wd;
    mem_readFin = v.in.m_fin;
    mem_radData = v.in.m_data;
    #1;
    got = '{f_fin: f_readFin, f_data: f_readData, e_fin: e_fin, e_data: e_readData,
            rd: mem_readEn, raddr: mem_readAddr, wr: mem_writeEn, waddr: mem_writeAddr,
            wdata: mem_writeData, to: timeoutErr};
    n_vec++;
    if (got !== v.exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", v.name, got, v.exp);
    end
  endtask

  initial begin
    vec_t v;

    // Reset, then a fetch whose memory answers two cycles after mem_readEn.
    add("rst_cycle",     mk_in(1, 0, 0,      0, 0, 0, 0, 0, 0),            o_none());
    add("reset_idle",    mk_in(0, 0, 0,      0, 0, 0, 0, 0, 0),            o_none());
    add("f_req_idle",    mk_in(0, 1, 32'h100, 0, 0, 0, 0, 0, 0),           o_none());
    add("f_wait1",       mk_in(0, 1, 32'h100, 0, 0, 0, 0, 0, 0),           o_rd(32'h100));
    add("f_wait2",       mk_in(0, 1, 32'h100, 0, 0, 0, 0, 0, 0),           o_rd(32'h100));
    add("f_fin",         mk_in(0, 1, 32'h100, 0, 0, 0, 0, 1, 32'hDEADBEEF), o_ffin(32'h100, 32'hDEADBEEF));
    add("idle_ign_fin",  mk_in(0, 0, 0,      0, 0, 0, 0, 1, 32'h55),       o_none());
    // Contention after reset history (last=F): E, F, E.
    add("both_idle0",    mk_in(0, 1, 32'h300, 1, 0, 32'h200, 0, 0, 0),     o_none());
    add("arb_e1",        mk_in(0, 1, 32'h300, 1, 0, 32'h200, 0, 1, 32'hE0), o_efin(32'h200, 32'hE0));
    add("both_idle1",    mk_in(0, 1, 32'h300, 1, 0, 32'h200, 0, 0, 0),     o_none());
    add("arb_f2",        mk_in(0, 1, 32'h300, 1, 0, 32'h200, 0, 1, 32'hF0), o_ffin(32'h300, 32'hF0));
    add("both_idle2",    mk_in(0, 1, 32'h300, 1, 0, 32'h200, 0, 0, 0),     o_none());
    add("arb_e3",        mk_in(0, 1, 32'h300, 1, 0, 32'h200, 0, 1, 32'hE1), o_efin(32'h200, 32'hE1));
    add("drop_idle",     mk_in(0, 0, 0,      0, 0, 0, 0, 0, 0),            o_none());
    // Request dropped mid-grant: the grant still runs to completion.
    add("f_req2",        mk_in(0, 1, 32'h400, 0, 0, 0, 0, 0, 0),           o_none());
    add("f_dropped",     mk_in(0, 0, 32'h400, 0, 0, 0, 0, 0, 0),           o_rd(32'h400));
    add("f_dropped_fin", mk_in(0, 0, 32'h400, 0, 0, 0, 0, 1, 32'h77),      o_ffin(32'h400, 32'h77));
    // Read-modify-write store.
    add("st_idle",       mk_in(0, 0, 0, 1, 1, 32'h40, 32'h112233AA, 0, 0), o_none());
    add("st_rd_wait",    mk_in(0, 0, 0, 1, 1, 32'h40, 32'h112233AA, 0, 0), o_rd(32'h40));
    add("st_rd_fin",     mk_in(0, 0, 0, 1, 1, 32'h40, 32'h112233AA, 1, 32'h11223344), o_rd(32'h40));
    add("st_write",      mk_in(0, 0, 0, 1, 1, 32'h40, 32'h112233AA, 1, 32'h99),
        o_wr(32'h40, 32'h112233AA, 32'h11223344));
    add("st_after",      mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0),                 o_none());
    // Reset landing on the write cycle of a store.
    add("rw_idle",       mk_in(0, 0, 0, 1, 1, 32'h80, 32'hCAFEF00D, 0, 0), o_none());
    add("rw_rd_fin",     mk_in(0, 0, 0, 1, 1, 32'h80, 32'hCAFEF00D, 1, 32'h12345678), o_rd(32'h80));
    add("rw_rst",        mk_in(1, 0, 0, 1, 1, 32'h80, 32'hCAFEF00D, 0, 0), o_none());
    add("rw_post_rst",   mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0),                 o_none());

    foreach (tbl[i]) check(tbl[i]);

    // Watchdog: a fetch the memory never answers expires on its 255th grant cycle.
    v.name = "to_idle";
    v.in   = mk_in(0, 1, 32'h500, 0, 0, 0, 0, 0, 0);
    v.exp  = o_none();
    check(v);
    for (int k = 1; k <= 255; k++) begin
      v.name = (k < 255) ? "to_wait" : "to_expire";
      v.exp  = o_rd(32'h500);
      v.exp.to = (k == 255);
      check(v);
    end
    v.name = "to_back_idle";
    v.exp  = o_none();
    check(v);
    v.name = "to_regrant";
    v.exp  = o_rd(32'h500);
    check(v);
    v.name = "to_regrant_fin";
    v.in   = mk_in(0, 1, 32'h500, 0, 0, 0, 0, 1, 32'hABCD0123);
    v.exp  = o_ffin(32'h500, 32'hABCD0123);
    check(v);
    v.name = "to_final_idle";
    v.in   = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.exp  = o_none();
    check(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
